// File: rtl/video_timing_gen.sv
// ============================================================================
//  Module      : video_timing_gen
//  Description : Raster timing generator (hsync, vsync, de, x/y, line/frame
//                start pulses) in the pixel-clock domain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic        pix_clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [11:0] x_o,
    output logic [11:0] y_o,
    output logic        line_start_o,
    output logic        frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
            $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    localparam logic [11:0] c_H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] c_V_LAST    = 12'(V_TOTAL - 1);
    localparam logic [11:0] c_H_ACTIVE  = 12'(H_ACTIVE);
    localparam logic [11:0] c_V_ACTIVE  = 12'(V_ACTIVE);
    localparam logic [11:0] c_HS_FIRST  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_HS_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] c_VS_FIRST  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_VS_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;

    // Outputs decode the counter state before the edge, so they lag the
    // counters by exactly one cycle and stay aligned with each other.
    always_comb begin
        h_cnt_d       = '0;
        v_cnt_d       = '0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        de_d          = 1'b0;
        x_d           = '0;
        y_d           = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (en_i) begin
            if (h_cnt_q == c_H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == c_V_LAST) ? 12'd0 : v_cnt_q + 12'd1;
            end else begin
                h_cnt_d = h_cnt_q + 12'd1;
                v_cnt_d = v_cnt_q;
            end
            de_d          = (h_cnt_q < c_H_ACTIVE) && (v_cnt_q < c_V_ACTIVE);
            hsync_d       = (h_cnt_q >= c_HS_FIRST && h_cnt_q <= c_HS_LAST) ? HS_POL : ~HS_POL;
            vsync_d       = (v_cnt_q >= c_VS_FIRST && v_cnt_q <= c_VS_LAST) ? VS_POL : ~VS_POL;
            x_d           = h_cnt_q;
            y_d           = v_cnt_q;
            line_start_d  = (h_cnt_q == 12'd0);
            frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        end
    end

    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign de_o          = de_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Self-checking bench for video_timing_gen (default, small and
//                short-frame configurations running side by side).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [11:0] x;
        logic [11:0] y;
    } out_t;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        logic en;
        out_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en [3];
    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic        ls [3];
    logic        fs [3];
    logic [11:0] xo [3];
    logic [11:0] yo [3];

    always #5 clk = ~clk;

    // 0: 720p defaults, 1: tiny 8x6 raster with active-low syncs, 2: 720p lines, 10-line frame
    video_timing_gen u_def (
        .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en[0]),
        .hsync_o(hs[0]), .vsync_o(vs[0]), .de_o(de[0]), .x_o(xo[0]), .y_o(yo[0]),
        .line_start_o(ls[0]), .frame_start_o(fs[0]));

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_small (
        .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en[1]),
        .hsync_o(hs[1]), .vsync_o(vs[1]), .de_o(de[1]), .x_o(xo[1]), .y_o(yo[1]),
        .line_start_o(ls[1]), .frame_start_o(fs[1]));

    video_timing_gen #(
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_med (
        .pix_clk_i(clk), .rst_n_i(rst_n), .en_i(en[2]),
        .hsync_o(hs[2]), .vsync_o(vs[2]), .de_o(de[2]), .x_o(xo[2]), .y_o(yo[2]),
        .line_start_o(ls[2]), .frame_start_o(fs[2]));

    cfg_t cfg [3];
    int   mh [3];
    int   mv [3];
    out_t sbq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // measurement state
    bit   mon_on = 1'b0;
    logic prev_de0 = 1'b0, prev_hs0 = 1'b0, prev_vs2 = 1'b0;
    int   de_rise0 = -1, de_fall0 = -1, de_rise1 = -1, hs_rise0 = -1, hs_fall0 = -1;
    int   ls0 = -1, ls1 = -1, fs0 = -1, fs1 = -1, vr = -1, vf = -1;
    int   lastx = -1, lasty = -1;

    function automatic out_t mk(logic h, logic v, logic d, logic l, logic f, int x, int y);
        out_t o;
        o.hs = h; o.vs = v; o.de = d; o.ls = l; o.fs = f;
        o.x = 12'(x); o.y = 12'(y);
        return o;
    endfunction

    function automatic out_t idle_out(int k);
        return mk(!cfg[k].hp, !cfg[k].vp, 1'b0, 1'b0, 1'b0, 0, 0);
    endfunction

    function automatic out_t sample(int k);
        return mk(hs[k], vs[k], de[k], ls[k], fs[k], int'(xo[k]), int'(yo[k]));
    endfunction

    task automatic model_step(input int k, output out_t e);
        int hsb, vsb;
        cfg_t c;
        c = cfg[k];
        if (!rst_n || !en[k]) begin
            e = idle_out(k);
            mh[k] = 0;
            mv[k] = 0;
        end else begin
            hsb = c.ha + c.hfp;
            vsb = c.va + c.vfp;
            e = mk((mh[k] >= hsb && mh[k] < hsb + c.hsw) ? c.hp : !c.hp,
                   (mv[k] >= vsb && mv[k] < vsb + c.vsw) ? c.vp : !c.vp,
                   (mh[k] < c.ha) && (mv[k] < c.va),
                   mh[k] == 0, mh[k] == 0 && mv[k] == 0, mh[k], mv[k]);
            mh[k] = mh[k] + 1;
            if (mh[k] == c.ha + c.hfp + c.hsw + c.hbp) begin
                mh[k] = 0;
                mv[k] = (mv[k] + 1) % (c.va + c.vfp + c.vsw + c.vbp);
            end
        end
    endtask

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic monitor();
        if (de[0] && !prev_de0 && de_rise0 < 0) de_rise0 = cyc;
        if (!de[0] && prev_de0 && de_rise0 >= 0 && de_fall0 < 0) de_fall0 = cyc;
        if (de[0] && !prev_de0 && de_fall0 >= 0 && de_rise1 < 0) de_rise1 = cyc;
        if (hs[0] && !prev_hs0 && de_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = cyc;
        if (!hs[0] && prev_hs0 && hs_rise0 >= 0 && hs_fall0 < 0) hs_fall0 = cyc;
        if (ls[0]) begin
            if (ls0 < 0) ls0 = cyc;
            else if (ls1 < 0) ls1 = cyc;
        end
        if (fs[2]) begin
            if (fs0 < 0) fs0 = cyc;
            else if (fs1 < 0) fs1 = cyc;
        end
        if (vs[2] && !prev_vs2 && vr < 0) vr = cyc;
        if (!vs[2] && prev_vs2 && vr >= 0 && vf < 0) vf = cyc;
        if (de[2] && fs0 >= 0 && fs1 < 0) begin
            lastx = int'(xo[2]);
            lasty = int'(yo[2]);
        end
        prev_de0 = de[0];
        prev_hs0 = hs[0];
        prev_vs2 = vs[2];
    endtask

    // Predict every instance before the edge, compare after it.
    task automatic tick();
        out_t e, a;
        for (int k = 0; k < 3; k++) begin
            model_step(k, e);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            e = sbq.pop_front();
            a = sample(k);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb_inst%0d cyc %0d got %h want %h", k, cyc, a, e);
            end
        end
        if (mon_on) monitor();
    endtask

    vec_t tbl [13];

    initial begin
        out_t a;
        bit   found;

        cfg[0] = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
        cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0};
        cfg[2] = '{1280, 110, 40, 220, 6, 1, 2, 1, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            mh[k] = 0;
            mv[k] = 0;
        end

        //              en     hs    vs    de    ls    fs    x  y
        tbl[0]  = '{1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0)};
        tbl[1]  = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0)};
        tbl[2]  = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};
        tbl[3]  = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0)};
        tbl[4]  = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 0)};
        tbl[5]  = '{1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0)};
        tbl[6]  = '{1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 0)};
        tbl[7]  = '{1'b1, mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6, 0)};
        tbl[8]  = '{1'b1, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7, 0)};
        tbl[9]  = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1)};
        tbl[10] = '{1'b0, mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0)};
        tbl[11] = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0)};
        tbl[12] = '{1'b1, mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0)};

        // Reset held with en high: everything stays idle.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) en[k] = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) tick();

        for (int k = 0; k < 3; k++) en[k] = 1'b0;
        rst_n = 1'b1;

        // Hand-computed vectors on the small raster.
        for (int i = 0; i < 13; i++) begin
            en[1] = tbl[i].en;
            tick();
            a = sample(1);
            checks++;
            if (a !== tbl[i].exp) begin
                errors++;
                $display("FAIL table row %0d got %h want %h", i, a, tbl[i].exp);
            end
        end

        // Free run of all three rasters from origin.
        en[1] = 1'b0;
        tick();
        mon_on = 1'b1;
        for (int k = 0; k < 3; k++) en[k] = 1'b1;
        for (int i = 0; i < 2 * 16500 + 20; i++) tick();
        mon_on = 1'b0;

        chk("de_high_len", de_fall0 - de_rise0, 1280);
        chk("de_low_len", de_rise1 - de_fall0, 370);
        chk("hs_after_de_fall", hs_rise0 - de_fall0, 110);
        chk("hs_width", hs_fall0 - hs_rise0, 40);
        chk("line_period", ls1 - ls0, 1650);
        chk("frame_period", fs1 - fs0, 16500);
        chk("vs_start", vr - fs0, 7 * 1650);
        chk("vs_width", vf - vr, 2 * 1650);
        chk("last_de_x", lastx, 1279);
        chk("last_de_y", lasty, 5);

        // en drop mid-frame on the short-frame raster.
        found = 1'b0;
        for (int i = 0; i < 17000; i++) begin
            if (mh[2] == 500 && mv[2] == 3) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("drop_reach_pos", int'(found), 1);
        en[2] = 1'b0;
        tick();
        chk("drop_idle_de", int'(de[2]), 0);
        chk("drop_idle_x", int'(xo[2]), 0);
        chk("drop_idle_y", int'(yo[2]), 0);
        tick();
        tick();
        en[2] = 1'b1;
        tick();
        chk("resume_fs", int'(fs[2]), 1);
        chk("resume_de", int'(de[2]), 1);
        chk("resume_x", int'(xo[2]), 0);
        chk("resume_y", int'(yo[2]), 0);

        // Asynchronous reset pulse between clock edges.
        for (int i = 0; i < 5; i++) tick();
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            a = sample(k);
            checks++;
            if (a !== idle_out(k)) begin
                errors++;
                $display("FAIL areset_inst%0d got %h want %h", k, a, idle_out(k));
            end
            mh[k] = 0;
            mv[k] = 0;
        end
        #1 rst_n = 1'b1;
        tick();
        chk("areset_restart_fs", int'(fs[1]), 1);
        chk("areset_restart_de", int'(de[0]), 1);
        chk("areset_restart_x", int'(xo[2]), 0);
        for (int i = 0; i < 20; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
